// File: rtl/traffic_controller_param.sv
// T-junction signal controller: tick-prescaled phase timing, demand-based phase skipping,
// emergency pre-emption and night flashing. State, phase and every lamp output are registered.
module traffic_controller_param #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] demand,
    input  logic       preempt_req,
    input  logic [1:0] preempt_dir,
    input  logic       flash_mode,
    output logic [2:0] w_to_e,
    output logic [2:0] w_to_n,
    output logic [2:0] e_to_w,
    output logic [2:0] e_to_n,
    output logic [2:0] n_to_e,
    output logic [2:0] n_to_w,
    output logic [1:0] phase,
    output logic [2:0] state
);
    localparam int MAX_GY    = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
    localparam int MAX_TICKS = (MAX_GY > ALLRED_TICKS) ? MAX_GY : ALLRED_TICKS;
    localparam int PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] GREEN_LD   = DW'(GREEN_TICKS - 1);
    localparam logic [DW-1:0] YELLOW_LD  = DW'(YELLOW_TICKS - 1);
    localparam logic [DW-1:0] ALLRED_LD  = DW'(ALLRED_TICKS - 1);

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    typedef enum logic [2:0] {
        S_GREEN     = 3'd0,
        S_YELLOW    = 3'd1,
        S_ALL_RED   = 3'd2,
        S_PRE_GREEN = 3'd3,
        S_FLASH     = 3'd4
    } state_t;

    state_t        st_q, st_d;
    logic [1:0]    ph_q, ph_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          flash_q, flash_d;
    logic [2:0]    lamp_w_q, lamp_e_q, lamp_n_q;
    logic [2:0]    lamp_w_d, lamp_e_d, lamp_n_d;
    logic [2:0]    own_lamp;
    logic          has_owner;
    logic          tick, expire, pre_pend;
    logic [1:0]    nxt1, nxt2, pick;

    function automatic logic [1:0] rot_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign tick     = (presc_q == PRESC_LAST);
    assign expire   = tick && (cnt_q == '0);
    assign pre_pend = preempt_req && (preempt_dir != 2'd3);

    // Demand scan starts after the current owner and only wraps back to it last.
    assign nxt1 = rot_next(ph_q);
    assign nxt2 = rot_next(nxt1);
    always_comb begin
        pick = nxt1;
        if (demand[nxt1])      pick = nxt1;
        else if (demand[nxt2]) pick = nxt2;
        else if (demand[ph_q]) pick = ph_q;
    end

    always_comb begin
        st_d    = st_q;
        ph_d    = ph_q;
        flash_d = flash_q;
        case (st_q)
            S_GREEN: begin
                if (pre_pend)                  st_d = (preempt_dir == ph_q) ? S_PRE_GREEN : S_YELLOW;
                else if (flash_mode || expire) st_d = S_YELLOW;
            end
            S_YELLOW: if (expire) st_d = S_ALL_RED;
            S_ALL_RED: begin
                if (expire) begin
                    if (pre_pend) begin
                        st_d = S_PRE_GREEN;
                        ph_d = preempt_dir;
                    end else if (flash_mode) begin
                        st_d = S_FLASH;
                    end else begin
                        st_d = S_GREEN;
                        ph_d = pick;
                    end
                end
            end
            S_PRE_GREEN: if (!pre_pend || preempt_dir != ph_q) st_d = S_YELLOW;
            S_FLASH: begin
                // Parking the phase on N makes the post-flash scan begin at W.
                if (pre_pend || !flash_mode) begin
                    st_d = S_ALL_RED;
                    ph_d = 2'd2;
                end else if (tick) begin
                    flash_d = ~flash_q;
                end
            end
            default: st_d = S_ALL_RED;
        endcase

        if (st_d != st_q) begin
            presc_d = '0;
            case (st_d)
                S_GREEN:     cnt_d = GREEN_LD;
                S_YELLOW:    cnt_d = YELLOW_LD;
                S_PRE_GREEN: cnt_d = cnt_q;
                default:     cnt_d = ALLRED_LD;
            endcase
            if (st_d == S_FLASH) flash_d = 1'b1;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            cnt_d   = (tick && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        end
    end

    // Lamp codes are derived from the next state so they register alongside it.
    always_comb begin
        lamp_w_d  = LAMP_R;
        lamp_e_d  = LAMP_R;
        lamp_n_d  = LAMP_R;
        own_lamp  = LAMP_R;
        has_owner = 1'b0;
        case (st_d)
            S_GREEN, S_PRE_GREEN: begin own_lamp = LAMP_G; has_owner = 1'b1; end
            S_YELLOW:             begin own_lamp = LAMP_Y; has_owner = 1'b1; end
            S_FLASH: begin
                lamp_w_d = flash_d ? LAMP_Y : LAMP_OFF;
                lamp_e_d = flash_d ? LAMP_Y : LAMP_OFF;
                lamp_n_d = flash_d ? LAMP_Y : LAMP_OFF;
            end
            default: ;
        endcase
        if (has_owner) begin
            case (ph_d)
                2'd0:    lamp_w_d = own_lamp;
                2'd1:    lamp_e_d = own_lamp;
                default: lamp_n_d = own_lamp;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q     <= S_ALL_RED;
            ph_q     <= 2'd2;
            presc_q  <= '0;
            cnt_q    <= ALLRED_LD;
            flash_q  <= 1'b0;
            lamp_w_q <= LAMP_R;
            lamp_e_q <= LAMP_R;
            lamp_n_q <= LAMP_R;
        end else begin
            st_q     <= st_d;
            ph_q     <= ph_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            flash_q  <= flash_d;
            lamp_w_q <= lamp_w_d;
            lamp_e_q <= lamp_e_d;
            lamp_n_q <= lamp_n_d;
        end
    end

    assign w_to_e = lamp_w_q;
    assign w_to_n = lamp_w_q;
    assign e_to_w = lamp_e_q;
    assign e_to_n = lamp_e_q;
    assign n_to_e = lamp_n_q;
    assign n_to_w = lamp_n_q;
    assign phase  = ph_q;
    assign state  = st_q;

endmodule

// File: tb/tb_traffic_controller_param.sv
// Directed bench for traffic_controller_param: table of timed segments (inputs plus expected
// lamps/state/phase per cycle) and a hand-written asynchronous mid-phase reset sequence.
`timescale 1ns/1ps
module tb_traffic_controller_param;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, D = 3'b000;
    localparam logic [2:0] ST_G = 3'd0, ST_Y = 3'd1, ST_AR = 3'd2, ST_PG = 3'd3, ST_FL = 3'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] demand = 3'b000;
    logic       preempt_req = 1'b0;
    logic [1:0] preempt_dir = 2'd0;
    logic       flash_mode = 1'b0;
    logic [2:0] w_to_e, w_to_n, e_to_w, e_to_n, n_to_e, n_to_w;
    logic [1:0] phase;
    logic [2:0] state;

    traffic_controller_param #(
        .TICK_DIV(2), .GREEN_TICKS(4), .YELLOW_TICKS(2), .ALLRED_TICKS(1)
    ) dut (
        .clk(clk), .rst(rst), .demand(demand), .preempt_req(preempt_req),
        .preempt_dir(preempt_dir), .flash_mode(flash_mode),
        .w_to_e(w_to_e), .w_to_n(w_to_n), .e_to_w(e_to_w), .e_to_n(e_to_n),
        .n_to_e(n_to_e), .n_to_w(n_to_w), .phase(phase), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst_first;
        logic [2:0] demand;
        logic       preq;
        logic [1:0] pdir;
        logic       flash;
        logic [2:0] st;
        logic [1:0] ph;
        logic [2:0] w, e, n;
        int         cycles;
    } seg_t;

    seg_t segs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic seg_t mk(bit rf, logic [2:0] dm, logic pq, logic [1:0] pd, logic fl,
                                logic [2:0] st, logic [1:0] ph, logic [2:0] w, logic [2:0] e,
                                logic [2:0] n, int cyc);
        seg_t s;
        s.rst_first = rf; s.demand = dm; s.preq = pq; s.pdir = pd; s.flash = fl;
        s.st = st; s.ph = ph; s.w = w; s.e = e; s.n = n; s.cycles = cyc;
        return s;
    endfunction

    function automatic void add(bit rf, logic [2:0] dm, logic pq, logic [1:0] pd, logic fl,
                                logic [2:0] st, logic [1:0] ph, logic [2:0] w, logic [2:0] e,
                                logic [2:0] n, int cyc);
        segs.push_back(mk(rf, dm, pq, pd, fl, st, ph, w, e, n, cyc));
    endfunction

    task automatic check(input string name, input logic [2:0] st, input logic [1:0] ph,
                         input logic [2:0] w, input logic [2:0] e, input logic [2:0] n);
        logic [22:0] act, exp;
        act = {state, phase, w_to_e, w_to_n, e_to_w, e_to_n, n_to_e, n_to_w};
        exp = {st, ph, w, w, e, e, n, n};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got st=%0d ph=%0d w=%b/%b e=%b/%b n=%b/%b, expected st=%0d ph=%0d w=%b e=%b n=%b",
                     name, state, phase, w_to_e, w_to_n, e_to_w, e_to_n, n_to_e, n_to_w,
                     st, ph, w, e, n);
        end
    endtask

    // Leaves the bench 1 ns after a rising edge with reset just released.
    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic run_seg(input seg_t s, input int idx);
        if (s.rst_first) do_reset();
        demand      = s.demand;
        preempt_req = s.preq;
        preempt_dir = s.pdir;
        flash_mode  = s.flash;
        for (int c = 0; c < s.cycles; c++) begin
            check($sformatf("seg%0d.cyc%0d", idx, c), s.st, s.ph, s.w, s.e, s.n);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset and fixed-time rotation W -> E -> N -> W
        add(1, 0, 0, 0, 0, ST_AR, 2, R, R, R, 2);
        add(0, 0, 0, 0, 0, ST_G,  0, G, R, R, 8);
        add(0, 0, 0, 0, 0, ST_Y,  0, Y, R, R, 4);
        add(0, 0, 0, 0, 0, ST_AR, 0, R, R, R, 2);
        add(0, 0, 0, 0, 0, ST_G,  1, R, G, R, 8);
        add(0, 0, 0, 0, 0, ST_Y,  1, R, Y, R, 4);
        add(0, 0, 0, 0, 0, ST_AR, 1, R, R, R, 2);
        add(0, 0, 0, 0, 0, ST_G,  2, R, R, G, 8);
        add(0, 0, 0, 0, 0, ST_Y,  2, R, R, Y, 4);
        add(0, 0, 0, 0, 0, ST_AR, 2, R, R, R, 2);
        add(0, 0, 0, 0, 0, ST_G,  0, G, R, R, 8);
        // Demand skip: N only after W, N repeats, then E-only demand skips W
        add(1, 0, 0, 0, 0, ST_AR, 2, R, R, R, 2);
        add(0, 0, 0, 0, 0, ST_G,  0, G, R, R, 1);
        add(0, 4, 0, 0, 0, ST_G,  0, G, R, R, 7);
        add(0, 4, 0, 0, 0, ST_Y,  0, Y, R, R, 4);
        add(0, 4, 0, 0, 0, ST_AR, 0, R, R, R, 2);
        add(0, 4, 0, 0, 0, ST_G,  2, R, R, G, 8);
        add(0, 4, 0, 0, 0, ST_Y,  2, R, R, Y, 4);
        add(0, 4, 0, 0, 0, ST_AR, 2, R, R, R, 2);
        add(0, 2, 0, 0, 0, ST_G,  2, R, R, G, 8);
        add(0, 2, 0, 0, 0, ST_Y,  2, R, R, Y, 4);
        add(0, 2, 0, 0, 0, ST_AR, 2, R, R, R, 2);
        add(0, 2, 0, 0, 0, ST_G,  1, R, G, R, 2);
        // Pre-emption to N from W green (20-cycle pulse), then same-approach and direction change
        add(1, 0, 0, 0, 0, ST_AR, 2, R, R, R, 2);
        add(0, 0, 0, 0, 0, ST_G,  0, G, R, R, 2);
        add(0, 0, 1, 2, 0, ST_G,  0, G, R, R, 1);
        add(0, 0, 1, 2, 0, ST_Y,  0, Y, R, R, 4);
        add(0, 0, 1, 2, 0, ST_AR, 0, R, R, R, 2);
        add(0, 0, 1, 2, 0, ST_PG, 2, R, R, G, 13);
        add(0, 0, 0, 2, 0, ST_PG, 2, R, R, G, 1);
        add(0, 0, 0, 2, 0, ST_Y,  2, R, R, Y, 4);
        add(0, 0, 0, 2, 0, ST_AR, 2, R, R, R, 2);
        add(0, 0, 0, 0, 0, ST_G,  0, G, R, R, 2);
        add(0, 0, 1, 0, 0, ST_G,  0, G, R, R, 1);
        add(0, 0, 1, 0, 0, ST_PG, 0, G, R, R, 10);
        add(0, 0, 1, 1, 0, ST_PG, 0, G, R, R, 1);
        add(0, 0, 1, 1, 0, ST_Y,  0, Y, R, R, 4);
        add(0, 0, 1, 1, 0, ST_AR, 0, R, R, R, 2);
        add(0, 0, 1, 1, 0, ST_PG, 1, R, G, R, 3);
        add(0, 0, 0, 1, 0, ST_PG, 1, R, G, R, 1);
        add(0, 0, 0, 1, 0, ST_Y,  1, R, Y, R, 4);
        add(0, 0, 0, 1, 0, ST_AR, 1, R, R, R, 2);
        add(0, 0, 0, 1, 0, ST_G,  2, R, R, G, 2);
        // Flash requested during E green, then released back to W
        add(1, 0, 0, 0, 0, ST_AR, 2, R, R, R, 2);
        add(0, 0, 0, 0, 0, ST_G,  0, G, R, R, 8);
        add(0, 0, 0, 0, 0, ST_Y,  0, Y, R, R, 4);
        add(0, 0, 0, 0, 0, ST_AR, 0, R, R, R, 2);
        add(0, 0, 0, 0, 0, ST_G,  1, R, G, R, 3);
        add(0, 0, 0, 0, 1, ST_G,  1, R, G, R, 1);
        add(0, 0, 0, 0, 1, ST_Y,  1, R, Y, R, 4);
        add(0, 0, 0, 0, 1, ST_AR, 1, R, R, R, 2);
        add(0, 0, 0, 0, 1, ST_FL, 1, Y, Y, Y, 2);
        add(0, 0, 0, 0, 1, ST_FL, 1, D, D, D, 2);
        add(0, 0, 0, 0, 1, ST_FL, 1, Y, Y, Y, 2);
        add(0, 0, 0, 0, 0, ST_FL, 1, D, D, D, 1);
        add(0, 0, 0, 0, 0, ST_AR, 2, R, R, R, 2);
        add(0, 0, 0, 0, 0, ST_G,  0, G, R, R, 8);
        // Flash straight out of reset, pre-emption overrides it, flash resumes afterwards
        add(1, 0, 0, 0, 1, ST_AR, 2, R, R, R, 2);
        add(0, 0, 0, 0, 1, ST_FL, 2, Y, Y, Y, 2);
        add(0, 0, 0, 0, 1, ST_FL, 2, D, D, D, 1);
        add(0, 0, 1, 0, 1, ST_FL, 2, D, D, D, 1);
        add(0, 0, 1, 0, 1, ST_AR, 2, R, R, R, 2);
        add(0, 0, 1, 0, 1, ST_PG, 0, G, R, R, 2);
        add(0, 0, 0, 0, 1, ST_PG, 0, G, R, R, 1);
        add(0, 0, 0, 0, 1, ST_Y,  0, Y, R, R, 4);
        add(0, 0, 0, 0, 1, ST_AR, 0, R, R, R, 2);
        add(0, 0, 0, 0, 1, ST_FL, 0, Y, Y, Y, 2);
        // Pre-emption toward direction 3 is ignored
        add(1, 0, 1, 3, 0, ST_AR, 2, R, R, R, 2);
        add(0, 0, 1, 3, 0, ST_G,  0, G, R, R, 8);
        add(0, 0, 1, 3, 0, ST_Y,  0, Y, R, R, 4);
        add(0, 0, 1, 3, 0, ST_AR, 0, R, R, R, 2);
        add(0, 0, 1, 3, 0, ST_G,  1, R, G, R, 8);

        foreach (segs[i]) run_seg(segs[i], i);

        // Asynchronous reset in the middle of W yellow, away from any clock edge
        run_seg(mk(1, 0, 0, 0, 0, ST_AR, 2, R, R, R, 2), 100);
        run_seg(mk(0, 0, 0, 0, 0, ST_G,  0, G, R, R, 8), 101);
        run_seg(mk(0, 0, 0, 0, 0, ST_Y,  0, Y, R, R, 1), 102);
        #2;
        check("pre_async_rst", ST_Y, 0, Y, R, R);
        rst = 1'b0;
        #1;
        check("async_rst_immediate", ST_AR, 2, R, R, R);
        @(posedge clk);
        #1;
        check("async_rst_held", ST_AR, 2, R, R, R);
        run_seg(mk(1, 0, 0, 0, 0, ST_AR, 2, R, R, R, 2), 103);
        run_seg(mk(0, 0, 0, 0, 0, ST_G,  0, G, R, R, 8), 104);
        run_seg(mk(0, 0, 0, 0, 0, ST_Y,  0, Y, R, R, 4), 105);
        run_seg(mk(0, 0, 0, 0, 0, ST_AR, 0, R, R, R, 2), 106);
        run_seg(mk(0, 0, 0, 0, 0, ST_G,  1, R, G, R, 8), 107);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/traffic_controller_param.md
# traffic_controller_param

- Parametrised successor to the fixed-time T-junction traffic controller.
- Drives the same six movement outputs (west, east, north approaches; two movements each).
- Adds:
  - configurable phase durations via an internal tick prescaler,
  - demand-based phase skipping,
  - emergency pre-emption,
  - night flashing mode.
- Sits directly behind the signal-head drivers; every output is registered.

## Interface

Parameters:
- TICK_DIV, 50_000_000: clk cycles per timing tick (≥1)
- GREEN_TICKS, 20: green duration in ticks (≥1)
- YELLOW_TICKS, 3: yellow duration in ticks (≥1)
- ALLRED_TICKS, 1: all-red clearance in ticks (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- demand  in  3  vehicle request per approach: bit0 W, bit1 E, bit2 N
- preempt_req  in  1  emergency pre-emption request, level
- preempt_dir  in  2  pre-empted approach: 0 W, 1 E, 2 N, 3 ignored
- flash_mode  in  1  night flashing request, level
- w_to_e, w_to_n, e_to_w, e_to_n, n_to_e, n_to_w  out  3  lamp code {red, yellow, green}: 100 red, 010 yellow, 001 green, 000 dark
- phase  out  2  approach currently owning green/yellow: 0 W, 1 E, 2 N
- state  out  3  0 GREEN, 1 YELLOW, 2 ALL_RED, 3 PRE_GREEN, 4 FLASH

## Operation

- **Phase ownership.** One approach owns the junction at a time; both of its movements show the same lamp code.
  - W phase owns w_to_e and w_to_n; E phase owns e_to_w and e_to_n; N phase owns n_to_e and n_to_w.
  - All non-owning movements are 100, except in FLASH.
- **Timer.**
  - Prescaler counts 0..TICK_DIV-1; it is cleared on every state entry.
  - The duration counter is loaded with duration-1 on state entry and decrements on each tick.
  - A state exits on the tick at which the counter is 0, so a state lasts exactly duration×TICK_DIV cycles.
- **Normal cycle:** GREEN → YELLOW → ALL_RED → next GREEN.
- **Next phase, chosen on ALL_RED exit:**
  - If pre-emption is pending (preempt_req=1 and preempt_dir≠3): enter PRE_GREEN on preempt_dir.
  - Otherwise, scan the rotation W→E→N→W starting after the current phase, and take the first approach whose demand bit is 1 (sampled that cycle).
  - If no demand bit is set, take the next approach in rotation (fixed-time fallback).
- **Pre-emption** (preempt_req=1, preempt_dir≠3), evaluated every cycle:
  - In GREEN of another approach: go to YELLOW the next cycle.
  - In GREEN of the same approach: go to PRE_GREEN, keep green, and reload nothing.
  - YELLOW and ALL_RED always complete their full duration.
  - PRE_GREEN holds while preempt_req=1. When it drops, PRE_GREEN loads YELLOW the next cycle.
  - preempt_dir changing while in PRE_GREEN: go to YELLOW, and the normal clearance follows.
- **Flash** (flash_mode=1, no pending pre-emption):
  - GREEN goes to YELLOW the next cycle.
  - ALL_RED exits into FLASH.
  - In FLASH, all six outputs show 010 for one tick, then 000 for one tick, repeating, starting with 010.
  - When flash_mode=0, FLASH exits to ALL_RED (full duration); the next phase is chosen with the rotation reset so that W is scanned first.
  - A pre-emption request in FLASH exits to ALL_RED the next cycle.
- **Priority:** reset > pre-emption > flash > demand/rotation.

## Timing

- **Reset values:**
  - state = ALL_RED, phase = 2 (N), so W is scanned first.
  - All six outputs = 100.
  - Duration counter = ALLRED_TICKS-1; prescaler = 0.
- **Reset behaviour:**
  - Assertion is asynchronous and takes effect immediately, including mid-phase.
  - Release is synchronous to clk.
- **Output timing:**
  - Outputs, phase and state are registered and change in the same cycle as the state register.
  - Inputs are sampled on the rising edge; the response appears one cycle later.
  - Inputs are treated as synchronous; the integrator synchronises field signals upstream.
- **Counter widths:**
  - Prescaler: $clog2(TICK_DIV) bits (minimum 1).
  - Duration counter: $clog2(max duration) bits (minimum 1).
  - Neither counter wraps: both reload on every state entry.
- **Simultaneous events:** demand changes during GREEN have no effect until the next ALL_RED exit.

## Test plan

All scenarios use TICK_DIV=2, GREEN_TICKS=4, YELLOW_TICKS=2, ALLRED_TICKS=1.

- **Reset and fixed-time rotation.** Hold rst=0, then release with demand=000.
  - All outputs are 100 for 2 cycles, then W green (w_to_e=w_to_n=001) for 8 cycles.
  - W then shows 010 for 4 cycles, all-red for 2 cycles, then E green.
  - The rotation continues W→E→N.
- **Demand skip.** demand=100 throughout.
  - After the first W phase, E is skipped; N receives green after W's all-red.
  - N is followed by N again, because N is the only demanded approach.
- **Pre-emption from a different approach.** Pulse preempt_req=1, preempt_dir=2 for 20 cycles, starting 2 cycles into W green.
  - W yellow starts the next cycle and lasts 4 cycles, then 2 cycles all-red.
  - Then PRE_GREEN N (n_to_e=n_to_w=001) holds until preempt_req falls, then 4 cycles of yellow.
- **Flash mode.** Assert flash_mode during E green.
  - E yellow starts the next cycle, followed by all-red, then FLASH: all outputs 010/000 alternating every 2 cycles.
  - Deassert flash_mode: 2 cycles all-red, then W green.
- **Reset mid-phase.** Assert rst=0 asynchronously mid-yellow.
  - All outputs are 100 immediately, without waiting for a clk edge.
  - After release, the sequence restarts exactly as in the first scenario.
- **Ignored direction.** preempt_req=1 with preempt_dir=3: the normal sequence is unaltered.
